// File: rtl/smod_select_seq.sv
// smod_select_seq: z = ((a % c) == zero) ? c + 1 : a - 1 on signed DATAWIDTH-bit operands, via a bit-serial restoring divider.
// Latency: out_valid follows DATAWIDTH+2 edges counting the accept edge; with SMOD_SELECT_FASTPATH_EN, c == 0 or |a| < |c| takes 2.
// Backpressure: one op in flight; in_ready only in IDLE; the result is held in DONE until out_ready.
module smod_select_seq #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] zero,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] z,
  output logic                 div0
);

  localparam int CW = $clog2(DATAWIDTH);
  localparam logic [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIX    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;     // partial remainder, always < 2^(DATAWIDTH-1) between steps
  logic [DATAWIDTH-1:0] dvd_q, dvd_d;     // |a|, shifted out MSB first
  logic [DATAWIDTH:0]   dvs_q, dvs_d;     // |c|
  logic                 neg_q, neg_d;     // sign of a, applied to the remainder
  logic                 czero_q, czero_d; // divisor was zero
  logic [DATAWIDTH-1:0] e_q, e_d;         // a - 1
  logic [DATAWIDTH-1:0] f_q, f_d;         // c + 1
  logic [DATAWIDTH-1:0] zero_q, zero_d;
  logic [DATAWIDTH-1:0] z_q, z_d;
  logic                 div0_q, div0_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [DATAWIDTH:0]   a_ext, c_ext, mag_a, mag_c;
  logic [DATAWIDTH:0]   shifted, diff;
  logic [DATAWIDTH-1:0] g;
  logic                 unused_top;

  // Operand magnitudes at DATAWIDTH+1 bits so |-2^(DATAWIDTH-1)| is exact.
  always_comb begin
    a_ext = {a[DATAWIDTH-1], a};
    c_ext = {c[DATAWIDTH-1], c};
    mag_a = a[DATAWIDTH-1] ? ('0 - a_ext) : a_ext;
    mag_c = c[DATAWIDTH-1] ? ('0 - c_ext) : c_ext;
  end

  // The top bits are provably zero: |a| <= 2^(DATAWIDTH-1) and a kept trial difference is < |c|.
  assign unused_top = mag_a[DATAWIDTH] ^ diff[DATAWIDTH];

  // Next-state, divider step and result select.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    czero_d = czero_q;
    e_d     = e_q;
    f_d     = f_q;
    zero_d  = zero_q;
    z_d     = z_q;
    div0_d  = div0_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, dvd_q[DATAWIDTH-1]};
    diff    = shifted - dvs_q;
    // Remainder takes the dividend's sign. With c == 0 every trial subtract of
    // zero succeeds, so the remainder ends as |a| and g comes out as a itself.
    g       = neg_q ? ('0 - rem_q) : rem_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          zero_d  = zero;
          e_d     = a - ONE;
          f_d     = c + ONE;
          dvd_d   = mag_a[DATAWIDTH-1:0];
          dvs_d   = mag_c;
          neg_d   = a[DATAWIDTH-1];
          czero_d = (c == '0);
          rem_d   = '0;
          cnt_d   = CW'(DATAWIDTH - 1);
          state_d = DIVIDE;
`ifdef SMOD_SELECT_FASTPATH_EN
          // Quotient is zero (or undefined): the remainder is |a| directly.
          if ((c == '0) || (mag_a < mag_c)) begin
            rem_d   = mag_a[DATAWIDTH-1:0];
            state_d = FIX;
          end
`endif
        end
      end
      DIVIDE: begin
        dvd_d = {dvd_q[DATAWIDTH-2:0], 1'b0};
        if (shifted >= dvs_q) begin
          rem_d = diff[DATAWIDTH-1:0];
        end else begin
          rem_d = shifted[DATAWIDTH-1:0];
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        z_d     = (g == zero_q) ? f_q : e_q;
        div0_d  = czero_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      czero_q <= 1'b0;
      e_q     <= '0;
      f_q     <= '0;
      zero_q  <= '0;
      z_q     <= '0;
      div0_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      czero_q <= czero_d;
      e_q     <= e_d;
      f_q     <= f_d;
      zero_q  <= zero_d;
      z_q     <= z_d;
      div0_q  <= div0_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z         = z_q;
  assign div0      = div0_q;

endmodule
